// File: rtl/divider_arbiter.sv
// divider_arbiter: round-robin sharing of one req/ack divider among CLIENTS requesters (optional DIV_ZERO_BYPASS_EN answers divisor-0 locally)
module divider_arbiter #(
  parameter int WIDTH   = 8,
  parameter int CLIENTS = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic [CLIENTS-1:0]       cl_req,
  input  logic [CLIENTS*WIDTH-1:0] cl_dividend,
  input  logic [CLIENTS*WIDTH-1:0] cl_divisor,
  output logic [CLIENTS-1:0]       cl_ack,
  output logic [WIDTH-1:0]         cl_quotient,
  output logic [WIDTH-1:0]         cl_remainder,
  output logic                     div_req,
  output logic [WIDTH-1:0]         div_dividend,
  output logic [WIDTH-1:0]         div_divisor,
  input  logic [WIDTH-1:0]         div_quotient,
  input  logic [WIDTH-1:0]         div_remainder,
  input  logic                     div_ack
);
  localparam int IW = (CLIENTS > 1) ? $clog2(CLIENTS) : 1;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, BYPASS} state_t;
  state_t state;
  logic [IW-1:0] grant, last_grant, pick;
  logic [CLIENTS-1:0] eligible;
  logic found;
  logic [WIDTH-1:0] sel_dividend, sel_divisor;
  // cl_ack is one-hot at last_grant, so masking by it holds off the client just served
  assign eligible = cl_req & ~cl_ack;
  assign sel_dividend = WIDTH'(cl_dividend >> (int'(pick) * WIDTH));
  assign sel_divisor = WIDTH'(cl_divisor >> (int'(pick) * WIDTH));
  // round-robin search from last_grant+1; descending loop leaves the nearest hit in pick
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = CLIENTS; k >= 1; k--)
      if (|(eligible & (CLIENTS'(1) << ((int'(last_grant) + k) % CLIENTS)))) begin
        found = 1'b1;
        pick = IW'((int'(last_grant) + k) % CLIENTS);
      end
  end
  // transaction FSM with registered divider and client outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      grant <= '0;
      last_grant <= IW'(CLIENTS - 1);
      div_req <= 1'b0;
      div_dividend <= '0;
      div_divisor <= '0;
      cl_ack <= '0;
      cl_quotient <= '0;
      cl_remainder <= '0;
    end else begin
      div_req <= 1'b0;
      cl_ack <= '0;
      case (state)
        IDLE: if (found) begin
          grant <= pick;
          div_dividend <= sel_dividend;
          div_divisor <= sel_divisor;
`ifdef DIV_ZERO_BYPASS_EN
          state <= (sel_divisor == '0) ? BYPASS : ISSUE;
          div_req <= (sel_divisor != '0);
`else
          state <= ISSUE;
          div_req <= 1'b1;
`endif
        end
        ISSUE: state <= WAIT;
        WAIT: if (div_ack) begin
          cl_quotient <= div_quotient;
          cl_remainder <= div_remainder;
          cl_ack <= CLIENTS'(1) << grant;
          last_grant <= grant;
          state <= IDLE;
        end
`ifdef DIV_ZERO_BYPASS_EN
        BYPASS: begin
          cl_quotient <= '1;
          cl_remainder <= div_dividend;
          cl_ack <= CLIENTS'(1) << grant;
          last_grant <= grant;
          state <= IDLE;
        end
`endif
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider_arbiter.sv
// tb_divider_arbiter: directed checks of grant order, latency, holdoff, reset abort and divide-by-zero handling
module tb_divider_arbiter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [1:0] cl_req = '0;
  logic [15:0] cl_dividend = '0, cl_divisor = '0;
  logic [1:0] cl_ack;
  logic [7:0] cl_quotient, cl_remainder, div_dividend, div_divisor;
  logic div_req;
  logic [7:0] div_quotient = '0, div_remainder = '0;
  logic div_ack = 1'b0;
  int tests = 0, fails = 0, req_cnt = 0, base;
  divider_arbiter #(.WIDTH(8), .CLIENTS(2)) dut (
    .clk(clk), .reset_n(reset_n), .cl_req(cl_req), .cl_dividend(cl_dividend),
    .cl_divisor(cl_divisor), .cl_ack(cl_ack), .cl_quotient(cl_quotient),
    .cl_remainder(cl_remainder), .div_req(div_req), .div_dividend(div_dividend),
    .div_divisor(div_divisor), .div_quotient(div_quotient),
    .div_remainder(div_remainder), .div_ack(div_ack)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (div_req) req_cnt <= req_cnt + 1;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic do_reset;
    reset_n = 1'b0;
    cl_req = '0;
    tick;
    tick;
    reset_n = 1'b1;
  endtask
  // wait for the request, check operands, answer after two cycles, check the client ack
  task automatic txn(input string tag, input logic [1:0] ack, input logic [7:0] dd, input logic [7:0] dv,
                     input logic [7:0] q, input logic [7:0] r, input bit drop);
    int n = 0;
    while (!div_req && n < 20) begin
      tick;
      n++;
    end
    chk({tag, " div_req"}, div_req, 1);
    chk({tag, " div_dividend"}, div_dividend, dd);
    chk({tag, " div_divisor"}, div_divisor, dv);
    tick;
    tick;
    div_quotient = q;
    div_remainder = r;
    div_ack = 1'b1;
    tick;
    div_ack = 1'b0;
    chk({tag, " cl_ack"}, cl_ack, ack);
    chk({tag, " quotient"}, cl_quotient, q);
    chk({tag, " remainder"}, cl_remainder, r);
    if (drop) cl_req = cl_req & ~ack;
  endtask
  initial begin
    do_reset;
    chk("reset outputs", {cl_ack, cl_quotient, cl_remainder, div_req, div_dividend, div_divisor}, 0);
    div_ack = 1'b1;
    tick;
    div_ack = 1'b0;
    chk("idle div_ack ignored", cl_ack, 0);
    cl_req = 2'b01;
    cl_dividend = {8'd0, 8'd100};
    cl_divisor = {8'd0, 8'd7};
    tick;
    chk("single div_req", div_req, 1);
    chk("single operands", {div_dividend, div_divisor}, {8'd100, 8'd7});
    cl_dividend = {8'd0, 8'd50};
    tick;
    chk("single req pulse", div_req, 0);
    chk("operand hold", div_dividend, 100);
    div_quotient = 8'd14;
    div_remainder = 8'd2;
    div_ack = 1'b1;
    tick;
    div_ack = 1'b0;
    cl_req = '0;
    chk("single ack", {cl_ack, cl_quotient, cl_remainder}, {2'b01, 8'd14, 8'd2});
    tick;
    chk("single ack pulse", {cl_ack, cl_quotient, div_req}, {2'b00, 8'd14, 1'b0});
    do_reset;
    base = req_cnt;
    cl_req = 2'b11;
    cl_dividend = {8'd255, 8'd200};
    cl_divisor = {8'd16, 8'd10};
    txn("simul c0", 2'b01, 8'd200, 8'd10, 8'd20, 8'd0, 1);
    txn("simul c1", 2'b10, 8'd255, 8'd16, 8'd15, 8'd15, 1);
    repeat (3) tick;
    chk("simul req count", req_cnt - base, 2);
    do_reset;
    cl_req = 2'b11;
    txn("fair 1", 2'b01, 8'd200, 8'd10, 8'd20, 8'd0, 0);
    txn("fair 2", 2'b10, 8'd255, 8'd16, 8'd15, 8'd15, 0);
    txn("fair 3", 2'b01, 8'd200, 8'd10, 8'd20, 8'd0, 0);
    txn("fair 4", 2'b10, 8'd255, 8'd16, 8'd15, 8'd15, 0);
    do_reset;
    cl_req = 2'b01;
    cl_dividend = {8'd0, 8'd100};
    cl_divisor = {8'd0, 8'd7};
    txn("hold first", 2'b01, 8'd100, 8'd7, 8'd14, 8'd2, 0);
    tick;
    chk("holdoff no grant", div_req, 0);
    tick;
    chk("holdoff regrant", div_req, 1);
    txn("hold second", 2'b01, 8'd100, 8'd7, 8'd14, 8'd2, 1);
    do_reset;
    base = req_cnt;
    cl_req = 2'b01;
    tick;
    tick;
    reset_n = 1'b0;
    cl_req = '0;
    tick;
    reset_n = 1'b1;
    chk("midwait reset outputs", {cl_ack, cl_quotient, cl_remainder, div_req, div_dividend, div_divisor}, 0);
    div_quotient = 8'd99;
    div_remainder = 8'd9;
    div_ack = 1'b1;
    tick;
    div_ack = 1'b0;
    chk("late ack ignored", {cl_ack, cl_quotient, cl_remainder, div_req}, 0);
    tick;
    chk("late ack single req", req_cnt - base, 1);
    cl_req = 2'b01;
    cl_dividend = {8'd0, 8'd200};
    cl_divisor = {8'd0, 8'd10};
    txn("post reset", 2'b01, 8'd200, 8'd10, 8'd20, 8'd0, 1);
    do_reset;
    base = req_cnt;
    cl_req = 2'b01;
    cl_dividend = {8'd0, 8'd37};
    cl_divisor = {8'd0, 8'd0};
`ifdef DIV_ZERO_BYPASS_EN
    tick;
    chk("bypass no req", {div_req, cl_ack}, 0);
    tick;
    cl_req = '0;
    chk("bypass ack", {cl_ack, cl_quotient, cl_remainder}, {2'b01, 8'd255, 8'd37});
    tick;
    chk("bypass req count", req_cnt - base, 0);
`else
    txn("div zero", 2'b01, 8'd37, 8'd0, 8'd255, 8'd37, 1);
    chk("div zero req count", req_cnt - base, 1);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/divider_arbiter.md
Name: divider_arbiter

Overview:
- Shares one req/ack unsigned divider among CLIENTS requesters in the scandoubler, e.g. horizontal/vertical scale-ratio and pixel-clock ratio calculators.
- Picks a requester round-robin, loads the divider operands and pulses the divider request.
- Waits for the divider ack, then returns quotient/remainder on a shared result bus with a per-client ack pulse.

Parameters:
- WIDTH, 8, operand/result width; must match the divider's width.
- CLIENTS, 2, number of requesters (2..8).

Ports:
- clk  input  1  clock
- reset_n  input  1  synchronous active-low reset
- cl_req  input  CLIENTS  per-client request level; held high until that client's cl_ack
- cl_dividend  input  CLIENTS*WIDTH  packed dividends, client i at [i*WIDTH +: WIDTH]; stable while cl_req[i] high
- cl_divisor  input  CLIENTS*WIDTH  packed divisors, same packing
- cl_ack  output  CLIENTS  one-cycle completion pulse, one-hot
- cl_quotient  output  WIDTH  result quotient; valid while any cl_ack bit is high, held until the next completion
- cl_remainder  output  WIDTH  result remainder, same timing
- div_req  output  1  one-cycle request to the divider
- div_dividend  output  WIDTH  registered operand to the divider
- div_divisor  output  WIDTH  registered operand to the divider
- div_quotient  input  WIDTH  divider result
- div_remainder  input  WIDTH  divider result
- div_ack  input  1  divider one-cycle done pulse; results valid in the same cycle

Behaviour:
- Reset (reset_n low at a clk edge) forces all outputs to 0, state to IDLE and last_grant to CLIENTS-1, so client 0 wins first.
- State IDLE:
  - Eligible = cl_req with the bit for the previous grant masked while cl_ack is high (ack holdoff).
  - If any client is eligible: grant the first one searching last_grant+1 upward, wrapping modulo CLIENTS.
  - On grant: register its operands onto div_dividend/div_divisor, store the grant index, go to ISSUE.
- State ISSUE: div_req=1 for exactly this cycle, go to WAIT.
- State WAIT, on div_ack:
  - Capture div_quotient/div_remainder into cl_quotient/cl_remainder.
  - Set cl_ack[grant]=1 for one cycle, last_grant<=grant, go to IDLE.
- Outside WAIT, div_ack is ignored.
- Latency: cl_req seen in IDLE at cycle N gives div_req at N+1; cl_ack comes one cycle after div_ack.
- Back-to-back: a new grant can occur in the same cycle cl_ack is high, for a client other than the one just acked.
- Operand changes after the grant do not affect the transaction in flight.
- A client dropping cl_req after the grant still gets its cl_ack; no abort.
- Reset during ISSUE/WAIT:
  - The transaction is dropped with no cl_ack.
  - The divider shares reset_n.
  - A late div_ack after reset is ignored because the state is IDLE.
- Only one transaction is outstanding; there is no queueing beyond the cl_req levels.

Optional Feature:
- Macro: DIV_ZERO_BYPASS_EN.
- Defined: in IDLE, a granted client with divisor==0 does not use the divider.
  - No div_req; the state passes through a one-cycle BYPASS.
  - Next cycle: cl_quotient={WIDTH{1'b1}}, cl_remainder=dividend, cl_ack[grant] pulses, last_grant updates.
  - Ack arrives 2 cycles after the grant cycle.
- Undefined: divisor 0 is sent to the divider like any other value; the result is whatever the divider returns (all-ones quotient, remainder=dividend for the team's divider).

Test Plan:
- Single (WIDTH=8, CLIENTS=2): client0 req 100/7 → div_req one cycle after grant; on div_ack, cl_ack=2'b01, q=14, r=2.
- Simultaneous after reset: client0 200/10 and client1 255/16 → client0 first (q=20, r=0), then client1 (q=15, r=15); div_req pulses exactly twice.
- Fairness: both cl_req held high for 4 transactions → cl_ack order 01,10,01,10.
- Holdoff: client0 alone keeps cl_req high one cycle past cl_ack → no grant in the ack cycle; a second grant occurs one cycle later.
- Reset asserted mid-WAIT, then div_ack pulsed after release → all outputs 0, no cl_ack, no div_req, next request served normally.
- 37/0, macro on → q=255, r=37, no div_req, cl_ack 2 cycles after grant. Macro off → div_req issued and the divider result returned.
